// File: rtl/mc_control_fsm.sv
// Multi-cycle MIPS control unit: owns its state register, waits on memory with a timeout,
// resolves branches in EX_BR and parks in a sticky TRAP state on illegal opcodes or timeouts.
module mc_control_fsm #(
   parameter logic [31:0] BOOT_WORD   = 32'h241D3FFC,
   parameter int          MEM_TIMEOUT = 15,
   parameter int          TO_W        = 4,
   parameter logic [5:0]  LW_OPCODE   = 6'b100011
) (
   input  logic        clk,
   input  logic        reset,
   input  logic [31:0] instruction,
   input  logic        mem_ready,
   input  logic        alu_zero,
   output logic        pc_we,
   output logic [1:0]  pc_src,
   output logic        mem_req,
   output logic        mem_we,
   output logic        mem_in,
   output logic        ir_we,
   output logic        reg_we,
   output logic [1:0]  dst,
   output logic        reg_in,
   output logic        alu_src_a,
   output logic [1:0]  alu_src_b,
   output logic [1:0]  alu_op,
   output logic        retire,
   output logic        trap,
   output logic [1:0]  trap_cause,
   output logic [4:0]  state
);

   typedef enum logic [4:0] {
      S_BOOT   = 5'd0,
      S_IF     = 5'd1,
      S_ID     = 5'd2,
      S_EX_R   = 5'd3,
      S_EX_I   = 5'd4,
      S_EX_MEM = 5'd5,
      S_MEM_LW = 5'd6,
      S_MEM_SW = 5'd7,
      S_EX_BR  = 5'd8,
      S_JR     = 5'd9,
      S_JMP    = 5'd10,
      S_JAL    = 5'd11,
      S_WB_R   = 5'd12,
      S_WB_I   = 5'd13,
      S_WB_LW  = 5'd14,
      S_TRAP   = 5'd15
   } state_t;

   localparam logic [5:0] OP_RTYPE = 6'b000000;
   localparam logic [5:0] OP_J     = 6'b000010;
   localparam logic [5:0] OP_JAL   = 6'b000011;
   localparam logic [5:0] OP_BEQ   = 6'b000100;
   localparam logic [5:0] OP_BNE   = 6'b000101;
   localparam logic [5:0] OP_ADDI  = 6'b001000;
   localparam logic [5:0] OP_ADDIU = 6'b001001;
   localparam logic [5:0] OP_SW    = 6'b101011;
   localparam logic [5:0] F_ADD    = 6'b100000;
   localparam logic [5:0] F_ADDU   = 6'b100001;
   localparam logic [5:0] F_SUB    = 6'b100010;
   localparam logic [5:0] F_SLT    = 6'b101010;
   localparam logic [5:0] F_JR     = 6'b001000;

   localparam logic [TO_W-1:0] TIMEOUT = TO_W'(MEM_TIMEOUT);

   state_t          cur;
   state_t          id_next;
   logic [TO_W-1:0] wait_cnt;
   logic [TO_W-1:0] wait_next;
   logic            timed_out;
   logic [1:0]      cause;
   logic [5:0]      opcode;
   logic [5:0]      funct;
   logic            req_dec;
   logic            we_dec;
   logic            unused_fields;

   function automatic logic [TO_W-1:0] sat_inc(input logic [TO_W-1:0] v);
      return (&v) ? v : v + TO_W'(1);
   endfunction

   assign opcode        = instruction[31:26];
   assign funct         = instruction[5:0];
   assign unused_fields = ^instruction[25:6];
   assign wait_next     = sat_inc(wait_cnt);
   assign timed_out     = !mem_ready && (wait_next == TIMEOUT);

   always_comb begin
      id_next = S_TRAP;
      if (opcode == LW_OPCODE) begin
         id_next = S_EX_MEM;
      end else begin
         case (opcode)
            OP_RTYPE: begin
               case (funct)
                  F_ADD, F_ADDU, F_SUB, F_SLT: id_next = S_EX_R;
                  F_JR:                        id_next = S_JR;
                  default:                     id_next = S_TRAP;
               endcase
            end
            OP_ADDI, OP_ADDIU: id_next = S_EX_I;
            OP_SW:             id_next = S_EX_MEM;
            OP_BEQ, OP_BNE:    id_next = S_EX_BR;
            OP_J:              id_next = S_JMP;
            OP_JAL:            id_next = S_JAL;
            default:           id_next = S_TRAP;
         endcase
      end
   end

   // The wait counter idles at zero outside the memory-wait states, so every entry starts clean.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         cur      <= S_BOOT;
         wait_cnt <= '0;
         cause    <= 2'd0;
      end else begin
         wait_cnt <= '0;
         case (cur)
            S_BOOT: if (mem_ready && instruction == BOOT_WORD) cur <= S_IF;
            S_IF, S_MEM_LW, S_MEM_SW: begin
               if (mem_ready) begin
                  case (cur)
                     S_IF:     cur <= S_ID;
                     S_MEM_LW: cur <= S_WB_LW;
                     default:  cur <= S_IF;
                  endcase
               end else if (timed_out) begin
                  cur   <= S_TRAP;
                  cause <= 2'd2;
               end else begin
                  wait_cnt <= wait_next;
               end
            end
            S_ID: begin
               cur <= id_next;
               if (id_next == S_TRAP) cause <= 2'd1;
            end
            S_EX_R:   cur <= S_WB_R;
            S_EX_I:   cur <= S_WB_I;
            S_EX_MEM: cur <= (opcode == LW_OPCODE) ? S_MEM_LW : S_MEM_SW;
            S_EX_BR, S_JR, S_JMP, S_JAL, S_WB_R, S_WB_I, S_WB_LW: cur <= S_IF;
            S_TRAP:   cur <= S_TRAP;
            default:  cur <= S_TRAP;
         endcase
      end
   end

   always_comb begin
      pc_we     = 1'b0;
      pc_src    = 2'd0;
      req_dec   = 1'b0;
      we_dec    = 1'b0;
      mem_in    = 1'b0;
      ir_we     = 1'b0;
      reg_we    = 1'b0;
      dst       = 2'd0;
      reg_in    = 1'b0;
      alu_src_a = 1'b0;
      alu_src_b = 2'd0;
      alu_op    = 2'd0;
      retire    = 1'b0;
      case (cur)
         S_BOOT: begin
            ir_we   = 1'b1;
            req_dec = 1'b1;
         end
         S_IF: begin
            req_dec = 1'b1;
            ir_we   = mem_ready;
            pc_we   = mem_ready;
         end
         S_ID: alu_src_b = 2'd3;
         S_EX_R: begin
            alu_src_a = 1'b1;
            alu_src_b = 2'd1;
            alu_op    = (funct == F_SUB) ? 2'd1 : (funct == F_SLT) ? 2'd2 : 2'd0;
         end
         S_EX_I, S_EX_MEM: begin
            alu_src_a = 1'b1;
            alu_src_b = 2'd2;
         end
         S_MEM_LW: begin
            req_dec = 1'b1;
            mem_in  = 1'b1;
         end
         S_MEM_SW: begin
            req_dec = 1'b1;
            we_dec  = 1'b1;
            mem_in  = 1'b1;
            retire  = mem_ready;
         end
         S_EX_BR: begin
            alu_src_a = 1'b1;
            alu_src_b = 2'd1;
            alu_op    = 2'd1;
            pc_src    = 2'd1;
            pc_we     = (opcode == OP_BEQ) ? alu_zero : !alu_zero;
            retire    = 1'b1;
         end
         S_JR: begin
            pc_we  = 1'b1;
            pc_src = 2'd2;
            retire = 1'b1;
         end
         S_JMP: begin
            pc_we  = 1'b1;
            pc_src = 2'd3;
            retire = 1'b1;
         end
         S_JAL: begin
            reg_we = 1'b1;
            dst    = 2'd2;
            reg_in = 1'b1;
            pc_we  = 1'b1;
            pc_src = 2'd3;
            retire = 1'b1;
         end
         S_WB_R: begin
            reg_we = 1'b1;
            reg_in = 1'b1;
            retire = 1'b1;
         end
         S_WB_I: begin
            reg_we = 1'b1;
            reg_in = 1'b1;
            dst    = 2'd1;
            retire = 1'b1;
         end
         S_WB_LW: begin
            reg_we = 1'b1;
            dst    = 2'd1;
            retire = 1'b1;
         end
         default: ;
      endcase
   end

   // Gating with reset drops the request and any write the instant reset rises.
   assign mem_req    = req_dec && !reset;
   assign mem_we     = we_dec && mem_req;
   assign trap       = (cur == S_TRAP);
   assign trap_cause = cause;
   assign state      = cur;

endmodule

// File: tb/tb_mc_control_fsm.sv
// Directed bench for mc_control_fsm: a vector table walks every instruction class,
// followed by hand sequences for memory timeout, illegal-opcode trap and reset.
module tb_mc_control_fsm;

   logic        clk = 1'b0;
   logic        reset;
   logic [31:0] instruction;
   logic        mem_ready;
   logic        alu_zero;
   logic        pc_we;
   logic [1:0]  pc_src;
   logic        mem_req;
   logic        mem_we;
   logic        mem_in;
   logic        ir_we;
   logic        reg_we;
   logic [1:0]  dst;
   logic        reg_in;
   logic        alu_src_a;
   logic [1:0]  alu_src_b;
   logic [1:0]  alu_op;
   logic        retire;
   logic        trap;
   logic [1:0]  trap_cause;
   logic [4:0]  state;

   mc_control_fsm dut (
      .clk(clk), .reset(reset), .instruction(instruction), .mem_ready(mem_ready),
      .alu_zero(alu_zero), .pc_we(pc_we), .pc_src(pc_src), .mem_req(mem_req),
      .mem_we(mem_we), .mem_in(mem_in), .ir_we(ir_we), .reg_we(reg_we), .dst(dst),
      .reg_in(reg_in), .alu_src_a(alu_src_a), .alu_src_b(alu_src_b), .alu_op(alu_op),
      .retire(retire), .trap(trap), .trap_cause(trap_cause), .state(state)
   );

   always #5 clk = ~clk;

   localparam logic [4:0] ST_BOOT = 5'd0,  ST_IF = 5'd1,   ST_ID = 5'd2,   ST_EXR = 5'd3;
   localparam logic [4:0] ST_EXI = 5'd4,   ST_EXM = 5'd5,  ST_MLW = 5'd6,  ST_MSW = 5'd7;
   localparam logic [4:0] ST_BR = 5'd8,    ST_JR = 5'd9,   ST_JMP = 5'd10, ST_JAL = 5'd11;
   localparam logic [4:0] ST_WBR = 5'd12,  ST_WBI = 5'd13, ST_WBLW = 5'd14, ST_TRAP = 5'd15;

   localparam logic [31:0] I_BOOT = 32'h241D3FFC, I_ADD = 32'h00221820, I_SUB = 32'h00222022;
   localparam logic [31:0] I_SLT = 32'h0022282A,  I_ADDI = 32'h20010005, I_ADDIU = 32'h24010005;
   localparam logic [31:0] I_LW = 32'h8C020004,   I_SW = 32'h AC020008,  I_BEQ = 32'h10220003;
   localparam logic [31:0] I_BNE = 32'h14220003,  I_J = 32'h08000010,    I_JAL = 32'h0C000010;
   localparam logic [31:0] I_JR = 32'h03E00008,   I_BAD = 32'hFC000000;

   typedef struct {
      logic [31:0] instr;
      logic        rdy;
      logic        az;
      logic [4:0]  st;
      logic [19:0] outs;
   } vec_t;

   vec_t        tbl[$];
   int          checks = 0;
   int          errors = 0;
   logic [19:0] act;

   logic [19:0] O_RST, O_BOOT, O_IFW, O_IFR, O_ID, O_EXRA, O_EXRS, O_EXRT, O_EXI;
   logic [19:0] O_WBR, O_WBI, O_WBLW, O_MLW, O_MSWW, O_MSWR, O_BRT, O_BRN;
   logic [19:0] O_JR, O_JMP, O_JAL, O_TRAP1, O_TRAP2;

   assign act = {pc_we, pc_src, mem_req, mem_we, mem_in, ir_we, reg_we, dst, reg_in,
                 alu_src_a, alu_src_b, alu_op, retire, trap, trap_cause};

   function automatic logic [19:0] pk(input logic pcwe, input logic [1:0] pcs, input logic mr,
      input logic mw, input logic mi, input logic irw, input logic rw, input logic [1:0] d,
      input logic ri, input logic sa, input logic [1:0] sb, input logic [1:0] op,
      input logic ret, input logic tr, input logic [1:0] tc);
      return {pcwe, pcs, mr, mw, mi, irw, rw, d, ri, sa, sb, op, ret, tr, tc};
   endfunction

   task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h", nm, got, exp);
      end
   endtask

   task automatic add(input logic [31:0] i, input logic r, input logic z,
                      input logic [4:0] s, input logic [19:0] o);
      vec_t v;
      v.instr = i; v.rdy = r; v.az = z; v.st = s; v.outs = o;
      tbl.push_back(v);
   endtask

   // Entered and left at 1 time unit after a rising edge.
   task automatic apply(input logic [31:0] i, input logic r, input logic z,
                        input logic [4:0] s, input logic [19:0] o, input string nm);
      instruction = i;
      mem_ready   = r;
      alu_zero    = z;
      #1;
      chk({nm, " state"}, 32'(state), 32'(s));
      chk({nm, " outs"}, 32'(act), 32'(o));
      @(posedge clk);
      #1;
   endtask

   task automatic pulse_reset();
      reset = 1'b1;
      @(posedge clk);
      #1;
      reset = 1'b0;
   endtask

   initial begin
      reset       = 1'b1;
      instruction = 32'h0;
      mem_ready   = 1'b0;
      alu_zero    = 1'b0;

      //          pcwe pcs mr mw mi irw rw dst ri sa sb op ret tr tc
      O_RST   = pk(0, 0, 0, 0, 0, 1, 0, 0, 0, 0, 0, 0, 0, 0, 0);
      O_BOOT  = pk(0, 0, 1, 0, 0, 1, 0, 0, 0, 0, 0, 0, 0, 0, 0);
      O_IFW   = pk(0, 0, 1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
      O_IFR   = pk(1, 0, 1, 0, 0, 1, 0, 0, 0, 0, 0, 0, 0, 0, 0);
      O_ID    = pk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 3, 0, 0, 0, 0);
      O_EXRA  = pk(0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 1, 0, 0, 0, 0);
      O_EXRS  = pk(0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 1, 1, 0, 0, 0);
      O_EXRT  = pk(0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 1, 2, 0, 0, 0);
      O_EXI   = pk(0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 2, 0, 0, 0, 0);
      O_WBR   = pk(0, 0, 0, 0, 0, 0, 1, 0, 1, 0, 0, 0, 1, 0, 0);
      O_WBI   = pk(0, 0, 0, 0, 0, 0, 1, 1, 1, 0, 0, 0, 1, 0, 0);
      O_WBLW  = pk(0, 0, 0, 0, 0, 0, 1, 1, 0, 0, 0, 0, 1, 0, 0);
      O_MLW   = pk(0, 0, 1, 0, 1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
      O_MSWW  = pk(0, 0, 1, 1, 1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
      O_MSWR  = pk(0, 0, 1, 1, 1, 0, 0, 0, 0, 0, 0, 0, 1, 0, 0);
      O_BRT   = pk(1, 1, 0, 0, 0, 0, 0, 0, 0, 1, 1, 1, 1, 0, 0);
      O_BRN   = pk(0, 1, 0, 0, 0, 0, 0, 0, 0, 1, 1, 1, 1, 0, 0);
      O_JR    = pk(1, 2, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 0, 0);
      O_JMP   = pk(1, 3, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 0, 0);
      O_JAL   = pk(1, 3, 0, 0, 0, 0, 1, 2, 1, 0, 0, 0, 1, 0, 0);
      O_TRAP1 = pk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 1);
      O_TRAP2 = pk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 2);

      add(32'h0,  0, 0, ST_BOOT, O_BOOT);
      add(I_BOOT, 1, 0, ST_BOOT, O_BOOT);
      add(I_ADD,  1, 0, ST_IF,   O_IFR);   add(I_ADD,  0, 0, ST_ID, O_ID);
      add(I_ADD,  0, 0, ST_EXR,  O_EXRA);  add(I_ADD,  0, 0, ST_WBR, O_WBR);
      add(I_SUB,  1, 0, ST_IF,   O_IFR);   add(I_SUB,  0, 0, ST_ID, O_ID);
      add(I_SUB,  0, 0, ST_EXR,  O_EXRS);  add(I_SUB,  0, 0, ST_WBR, O_WBR);
      add(I_SLT,  1, 0, ST_IF,   O_IFR);   add(I_SLT,  0, 0, ST_ID, O_ID);
      add(I_SLT,  0, 0, ST_EXR,  O_EXRT);  add(I_SLT,  0, 0, ST_WBR, O_WBR);
      add(I_ADDI, 1, 0, ST_IF,   O_IFR);   add(I_ADDI, 0, 0, ST_ID, O_ID);
      add(I_ADDI, 0, 0, ST_EXI,  O_EXI);   add(I_ADDI, 0, 0, ST_WBI, O_WBI);
      add(I_BEQ,  1, 1, ST_IF,   O_IFR);   add(I_BEQ,  0, 1, ST_ID, O_ID);
      add(I_BEQ,  0, 1, ST_BR,   O_BRT);
      add(I_BNE,  1, 1, ST_IF,   O_IFR);   add(I_BNE,  0, 1, ST_ID, O_ID);
      add(I_BNE,  0, 1, ST_BR,   O_BRN);
      add(I_BNE,  1, 0, ST_IF,   O_IFR);   add(I_BNE,  0, 0, ST_ID, O_ID);
      add(I_BNE,  0, 0, ST_BR,   O_BRT);
      add(I_LW,   1, 0, ST_IF,   O_IFR);   add(I_LW,   0, 0, ST_ID, O_ID);
      add(I_LW,   0, 0, ST_EXM,  O_EXI);   add(I_LW,   0, 0, ST_MLW, O_MLW);
      add(I_LW,   1, 0, ST_MLW,  O_MLW);   add(I_LW,   0, 0, ST_WBLW, O_WBLW);
      add(I_SW,   1, 0, ST_IF,   O_IFR);   add(I_SW,   0, 0, ST_ID, O_ID);
      add(I_SW,   0, 0, ST_EXM,  O_EXI);   add(I_SW,   0, 0, ST_MSW, O_MSWW);
      add(I_SW,   0, 0, ST_MSW,  O_MSWW);  add(I_SW,   1, 0, ST_MSW, O_MSWR);
      add(I_JAL,  1, 0, ST_IF,   O_IFR);   add(I_JAL,  0, 0, ST_ID, O_ID);
      add(I_JAL,  0, 0, ST_JAL,  O_JAL);
      add(I_JR,   1, 0, ST_IF,   O_IFR);   add(I_JR,   0, 0, ST_ID, O_ID);
      add(I_JR,   0, 0, ST_JR,   O_JR);
      add(I_J,    1, 0, ST_IF,   O_IFR);   add(I_J,    0, 0, ST_ID, O_ID);
      add(I_J,    0, 0, ST_JMP,  O_JMP);
      add(I_ADDIU,1, 0, ST_IF,   O_IFR);   add(I_ADDIU,0, 0, ST_ID, O_ID);
      add(I_ADDIU,0, 0, ST_EXI,  O_EXI);   add(I_ADDIU,0, 0, ST_WBI, O_WBI);

      // Reset state while reset is held
      @(posedge clk);
      @(posedge clk);
      #1;
      chk("reset state", 32'(state), 32'(ST_BOOT));
      chk("reset outs", 32'(act), 32'(O_RST));
      reset = 1'b0;

      foreach (tbl[i])
         apply(tbl[i].instr, tbl[i].rdy, tbl[i].az, tbl[i].st, tbl[i].outs,
               $sformatf("row%0d", i));

      // Fetch stalls three cycles, then completes; the counter must restart afterwards
      for (int i = 0; i < 3; i++)
         apply(I_ADD, 0, 0, ST_IF, O_IFW, $sformatf("stall%0d", i));
      apply(I_ADD, 1, 0, ST_IF, O_IFR, "stall done");
      apply(I_ADD, 0, 0, ST_ID, O_ID, "stall id");
      apply(I_ADD, 0, 0, ST_EXR, O_EXRA, "stall exr");
      apply(I_ADD, 0, 0, ST_WBR, O_WBR, "stall wbr");
      for (int i = 0; i < 15; i++)
         apply(I_ADD, 0, 0, ST_IF, O_IFW, $sformatf("timeout wait%0d", i));
      apply(I_ADD, 1, 0, ST_TRAP, O_TRAP2, "timeout trap");

      // Illegal opcode traps with cause 1 and stays there
      pulse_reset();
      apply(I_BOOT, 1, 0, ST_BOOT, O_BOOT, "boot2");
      apply(I_BAD, 1, 0, ST_IF, O_IFR, "bad if");
      apply(I_BAD, 0, 0, ST_ID, O_ID, "bad id");
      for (int i = 0; i < 10; i++)
         apply(I_BOOT, 1, 1, ST_TRAP, O_TRAP1, $sformatf("sticky%0d", i));
      reset = 1'b1;
      #1;
      chk("async reset state", 32'(state), 32'(ST_BOOT));
      chk("async reset trap", 32'(trap), 32'd0);
      chk("async reset cause", 32'(trap_cause), 32'd0);
      @(posedge clk);
      #1;
      reset = 1'b0;

      // Reset during a store must kill the request and the write immediately
      apply(I_BOOT, 1, 0, ST_BOOT, O_BOOT, "boot3");
      apply(I_SW, 1, 0, ST_IF, O_IFR, "rsw if");
      apply(I_SW, 0, 0, ST_ID, O_ID, "rsw id");
      apply(I_SW, 0, 0, ST_EXM, O_EXI, "rsw exm");
      instruction = I_SW;
      mem_ready   = 1'b0;
      #1;
      chk("rsw mem_we before reset", 32'(mem_we), 32'd1);
      reset = 1'b1;
      #1;
      chk("rsw mem_req", 32'(mem_req), 32'd0);
      chk("rsw mem_we", 32'(mem_we), 32'd0);
      chk("rsw state", 32'(state), 32'(ST_BOOT));
      @(posedge clk);
      #1;
      reset = 1'b0;

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
